// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // fetch_sel encodings driven by the pipeline control unit; 2'b11 behaves as NOP.
  localparam logic [1:0] FETCH_SEL_PC     = 2'b00;
  localparam logic [1:0] FETCH_SEL_NOP    = 2'b01;
  localparam logic [1:0] FETCH_SEL_BRANCH = 2'b10;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request outstanding,
// and hands one-cycle instruction pulses to decode. Redirects squash in-flight fetches.
//
// imem handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
// once valid is raised the address holds until that transfer. A response is the single
// cycle with imem_rsp_valid high, at least one cycle after the transfer.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         fetch_sel,
  input  logic [XLEN-1:0]    branch_target,
  input  logic               nop_output_fetch,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [31:0]        imem_rsp_data,
  output logic [31:0]        instr_out,
  output logic [XLEN-1:0]    pc_out,
  output logic               instr_valid,
  output logic [6:0]         opcode_fetch,
  output fetch_state_e       state
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] req_pc_q;
  logic            squash_q;
  logic [XLEN-1:0] target;
  logic            is_branch;
  logic            is_pc;

  assign target    = {branch_target[XLEN-1:2], 2'b00};
  assign is_branch = (fetch_sel == FETCH_SEL_BRANCH);
  assign is_pc     = (fetch_sel == FETCH_SEL_PC);

  // In IDLE a branch wins over fetching, so no request goes out on a redirect cycle.
  assign imem_req_valid = !rst && (((state == IDLE) && is_pc) || (state == REQ));
  assign imem_req_addr  = (state == REQ) ? req_addr_q : pc_q;
  assign opcode_fetch   = instr_out[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      squash_q    <= 1'b0;
      instr_out   <= NOP_INSTR;
      pc_out      <= RESET_PC;
      instr_valid <= 1'b0;
    end else begin
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (is_branch) begin
            pc_q <= target;
          end else if (is_pc) begin
            req_addr_q <= pc_q;
            if (imem_req_ready) begin
              req_pc_q <= pc_q;
              pc_q     <= pc_q + XLEN'(4);
              state    <= WAIT;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            req_pc_q <= req_addr_q;
            state    <= WAIT;
            // A redirect seen earlier in REQ already owns pc_q.
            if (!squash_q) pc_q <= req_addr_q + XLEN'(4);
          end
          if (is_branch) begin
            pc_q     <= target;
            squash_q <= 1'b1;
          end
        end
        WAIT: begin
          if (is_branch) begin
            pc_q <= target;
            if (imem_rsp_valid) begin
              state    <= IDLE;
              squash_q <= 1'b0;
            end else begin
              squash_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            state    <= IDLE;
            squash_q <= 1'b0;
            if (!squash_q) begin
              instr_out   <= nop_output_fetch ? NOP_INSTR : imem_rsp_data;
              pc_out      <= req_pc_q;
              instr_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: bench-side imem responder plus an expected-instruction queue.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   fetch_sel;
  logic [31:0]  branch_target;
  logic         nop_output_fetch;
  logic         imem_req_valid;
  logic [31:0]  imem_req_addr;
  logic         imem_req_ready;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic [31:0]  instr_out;
  logic [31:0]  pc_out;
  logic         instr_valid;
  logic [6:0]   opcode_fetch;
  fetch_state_e state;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  fetch_stage dut (
    .clk(clk), .rst(rst), .fetch_sel(fetch_sel), .branch_target(branch_target),
    .nop_output_fetch(nop_output_fetch), .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .opcode_fetch(opcode_fetch), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'd3) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input string tag, input logic [31:0] addr);
    #1;
    check({tag, "_valid"}, 32'(imem_req_valid), 32'd1);
    check({tag, "_addr"}, imem_req_addr, addr);
  endtask

  // Accept one request at addr, answer lat cycles later; keep=1 means decode should see it.
  task automatic fetch_one(input logic [31:0] addr, input int lat, input bit keep);
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b1;
    expect_req("fetch_req", addr);
    tick();
    imem_req_ready = 1'b0;
    fetch_sel = FETCH_SEL_NOP;
    repeat (lat - 1) tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mem_word(addr);
    if (keep) exp_q.push_back({addr, mem_word(addr)});
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  // scoreboard: every decode pulse must match the oldest expected fetch
  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(instr_valid), 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_pc", pc_out, e[63:32]);
        check("sb_instr", instr_out, e[31:0]);
        check("sb_opcode", 32'(opcode_fetch), 32'(e[6:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    fetch_sel = FETCH_SEL_NOP;
    branch_target = '0;
    nop_output_fetch = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr", instr_out, NOP);
    check("rst_pc", pc_out, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem_req_valid), 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // back-to-back fetches with 1-cycle memory
    fetch_one(32'h0, 1, 1'b1);
    fetch_one(32'h4, 1, 1'b1);
    fetch_one(32'h8, 1, 1'b1);

    // memory stalls: address must stay put while fetch_sel toggles
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b0;
    expect_req("stall0", 32'hC);
    tick();
    check("stall_state", 32'(state), 32'(REQ));
    for (int i = 0; i < 3; i++) begin
      fetch_sel = (i % 2 == 0) ? FETCH_SEL_NOP : 2'b11;
      expect_req("stall", 32'hC);
      tick();
    end
    fetch_one(32'hC, 2, 1'b1);

    // redirect while waiting; the late response is dropped
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b1;
    expect_req("br_wait_req", 32'h10);
    tick();
    imem_req_ready = 1'b0;
    fetch_sel = FETCH_SEL_BRANCH;
    branch_target = 32'h100;
    tick();
    fetch_sel = FETCH_SEL_NOP;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mem_word(32'h10);
    tick();
    imem_rsp_valid = 1'b0;
    check("br_wait_drop", 32'(instr_valid), 32'd0);
    check("br_wait_idle", 32'(state), 32'(IDLE));
    fetch_one(32'h100, 1, 1'b1);

    // redirect on the response cycle, unaligned target
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b1;
    expect_req("br_rsp_req", 32'h104);
    tick();
    imem_req_ready = 1'b0;
    fetch_sel = FETCH_SEL_BRANCH;
    branch_target = 32'h103;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mem_word(32'h104);
    tick();
    imem_rsp_valid = 1'b0;
    fetch_sel = FETCH_SEL_NOP;
    check("br_rsp_drop", 32'(instr_valid), 32'd0);
    fetch_one(32'h100, 1, 1'b1);

    // response replaced by a bubble, still a valid slot
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b1;
    expect_req("nop_req", 32'h104);
    tick();
    imem_req_ready = 1'b0;
    fetch_sel = FETCH_SEL_NOP;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00A0_0093;
    nop_output_fetch = 1'b1;
    exp_q.push_back({32'h104, NOP});
    tick();
    imem_rsp_valid = 1'b0;
    nop_output_fetch = 1'b0;
    check("nop_valid", 32'(instr_valid), 32'd1);
    check("nop_instr", instr_out, NOP);
    check("nop_pc", pc_out, 32'h104);

    // redirect on the same cycle a held request is accepted
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b0;
    expect_req("br_req_req", 32'h108);
    tick();
    fetch_sel = FETCH_SEL_BRANCH;
    branch_target = 32'h200;
    imem_req_ready = 1'b1;
    expect_req("br_req_hold", 32'h108);
    tick();
    fetch_sel = FETCH_SEL_NOP;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mem_word(32'h108);
    tick();
    imem_rsp_valid = 1'b0;
    check("br_req_drop", 32'(instr_valid), 32'd0);
    fetch_one(32'h200, 1, 1'b1);

    // PC wrap at the top of the address space
    fetch_sel = FETCH_SEL_BRANCH;
    branch_target = 32'hFFFF_FFFE;
    #1;
    check("br_idle_noreq", 32'(imem_req_valid), 32'd0);
    tick();
    fetch_one(32'hFFFF_FFFC, 1, 1'b1);

    // reset while waiting, then a stale response in IDLE
    fetch_sel = FETCH_SEL_PC;
    imem_req_ready = 1'b1;
    expect_req("wrap_req", 32'h0);
    tick();
    imem_req_ready = 1'b0;
    fetch_sel = FETCH_SEL_NOP;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_req", 32'(imem_req_valid), 32'd0);
    check("midrst_instr", instr_out, NOP);
    check("midrst_pc", pc_out, 32'h0);
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = mem_word(32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    check("late_rsp_valid", 32'(instr_valid), 32'd0);
    check("late_rsp_state", 32'(state), 32'(IDLE));
    fetch_one(32'h0, 3, 1'b1);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
